// File: rtl/tohost_sim_ctrl.sv
// tohost_sim_ctrl: bus-mapped test-completion peripheral.
// Reports pass/fail/timeout and the end cycle to the simulation host, and
// streams console bytes out through a small FIFO.
// Build option: define TOHOST_CONSOLE_EN to include the console FIFO;
// without it CONSOLE writes are ignored and the console outputs stay idle.
module tohost_sim_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'h0010_0000,
  parameter int unsigned CON_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [31:0] test_code_o,
  output logic [30:0] testnum_o,
  output logic [31:0] end_cycle_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i
);

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] counter_q, counter_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] code_q, code_d;
  logic [31:0] end_q, end_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel_tohost, sel_console, rd_req;
  logic        hit_result, hit_timeout;
  logic        fifo_empty, fifo_full, overflow;
  logic        unused_addr;

  assign sel_tohost  = req_i & we_i & (addr_i[7:2] == 6'd0);
  assign sel_console = req_i & we_i & (addr_i[7:2] == 6'd1);
  assign rd_req      = req_i & ~we_i;
  // Even TOHOST values are syscall requests and never end the test.
  assign hit_result  = sel_tohost & data_i[0];
  assign hit_timeout = TimeoutEn && (counter_q == TimeoutLast);
  assign unused_addr = ^addr_i[1:0];

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      counter_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= '0;
      end_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      code_q    <= code_d;
      end_q     <= end_d;
      rdata_q   <= rdata_d;
    end
  end

  // FSM next state: run until a result write or the watchdog; the write wins a tie.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    code_d    = code_q;
    end_d     = end_q;
    unique case (state_q)
      StRun: begin
        if (counter_q != 32'hFFFF_FFFF) counter_d = counter_q + 32'd1;
        if (hit_result) begin
          state_d = StDone;
          done_d  = 1'b1;
          code_d  = data_i;
          pass_d  = (data_i == 32'd1);
          end_d   = counter_q;
        end else if (hit_timeout) begin
          state_d   = StDone;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          code_d    = '0;
          end_d     = counter_q;
        end
      end
      StDone: ;
      default: state_d = StRun;
    endcase
  end

  // Registered read data; holds its value between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_req) begin
      unique case (addr_i[7:2])
        6'd2:    rdata_d = {27'b0, timeout_q, overflow, fifo_full, fifo_empty, done_q};
        6'd3:    rdata_d = counter_q;
        default: rdata_d = '0;
      endcase
    end
  end

`ifdef TOHOST_CONSOLE_EN
  localparam int unsigned PtrW     = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(CON_DEPTH);

  logic [7:0]      mem_q [CON_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            push, pop;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DepthCnt);
  assign overflow   = ovf_q;
  assign pop        = ~fifo_empty & con_ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push       = sel_console & (~fifo_full | pop);

  // FIFO pointer/occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (sel_console & fifo_full & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i[7:0];
  end

  assign con_valid_o = ~fifo_empty;
  assign con_data_o  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
`else
  logic unused_con;

  assign fifo_empty  = 1'b1;
  assign fifo_full   = 1'b0;
  assign overflow    = 1'b0;
  assign con_valid_o = 1'b0;
  assign con_data_o  = 8'h00;
  assign unused_con  = con_ready_i ^ sel_console ^ (CON_DEPTH == 0);
`endif

  assign data_o      = rdata_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign test_code_o = code_q;
  assign testnum_o   = code_q[31:1];
  assign end_cycle_o = end_q;

endmodule
